dbg_probe_capture: RTL
======================

// Module: dbg_probe_capture
// PURPOSE
//  - Parametrised probe front-end for the on-screen debug overlay: NCH probe words, paged onto LINES overlay lines.
//  - Tear-free display: values update only on VSync rising edge; masked-compare trigger freezes a one-cycle snapshot.
//  - Replaces ad-hoc DebugLx wiring and the free-running slow-clock divider in the top level; lines_o feeds overlay in0..in7.
// PARAMETERS
//  NCH       16         number of probe channels (>=1)
//  W         16         probe word width, bits
//  LINES     8          overlay lines per page
//  TICK_DIV  5000000    slow-tick period in clk_sys cycles (>=2), used only with DBG_TICK_EN
// PORTS
//  clk_sys      in   1              system clock; all logic on rising edge
//  reset        in   1              synchronous, active-high
//  probe_i      in   NCH*W          channel c = probe_i[c*W +: W]
//  vs_i         in   1              vertical sync, active high, clk_sys domain
//  freeze_i     in   1              1 = hold display shadow (no VSync updates)
//  page_i       in   8              page index; line k shows channel page_i*LINES+k
//  arm_i        in   1              1-cycle pulse: arm trigger
//  trig_ch_i    in   $clog2(NCH)    channel compared by trigger (max(1,..) bits)
//  trig_mask_i  in   W              compare mask, 1 = bit compared
//  trig_val_i   in   W              compare value
//  lines_o      out  LINES*W        overlay words, line k = lines_o[k*W +: W]
//  state_o      out  2              00 IDLE, 01 ARMED, 10 CAPTURED
//  triggered_o  out  1              1 while CAPTURED
//  hit_count_o  out  16             trigger hits since reset, saturates at 16'hFFFF
//  tick_o       out  1              slow tick pulse (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, shadow/capture regs 0, state IDLE, vs edge detector 0, tick counter 0.
//  - VSync edge: vs_rise = vs_i & ~vs_q (vs_q registered). On vs_rise & ~freeze_i, shadow <= probe_i (all channels).
//  - FSM:
//     IDLE:     arm_i -> ARMED. No compare performed in IDLE.
//     ARMED:    match = ((probe[trig_ch_i] ^ trig_val_i) & trig_mask_i) == 0, evaluated on live probe_i.
//               match -> capture <= probe_i (same cycle's values), hit_count+1 (sat), -> CAPTURED.
//               arm_i while ARMED: ignored. trig_ch_i >= NCH never matches.
//     CAPTURED: holds capture; arm_i -> ARMED (triggered_o drops next cycle). Capture content kept until next hit.
//  - arm_i in IDLE with match same cycle: go ARMED only; first compare on following cycle.
//  - mask all zero: matches on first ARMED cycle.
//  - Display source: capture when CAPTURED, else shadow. Shadow keeps updating in all states.
//  - lines_o registered: 1-cycle latency from source/page_i change. Channel index >= NCH reads 0.
//    Index = page_i*LINES+k computed at >=16 bits; no wrap-around of pages.
//  - Latency: probe match at cycle N -> state_o=10, triggered_o=1 at N+1; lines_o shows capture at N+2.
//  - VSync edge and hit same cycle: both updates occur (independent regs).
//  - Reset mid-CAPTURED: returns IDLE, capture and hit_count cleared, lines_o 0 next cycle.
// CONFIGURATION
//  - DBG_TICK_EN defined: TICK_DIV-cycle counter; tick_o high exactly 1 cycle every TICK_DIV cycles,
//    first pulse TICK_DIV cycles after reset release; counter restarts on reset. For single-step/slow-clock enable.
//  - DBG_TICK_EN undefined: no counter synthesised; tick_o tied 0.
// TESTING
//  1 Reset: hold reset 3 cycles with probe_i nonzero -> lines_o=0, state_o=00, hit_count_o=0, tick_o=0.
//  2 Paging: NCH=16,LINES=8, ch c = 16'h1000+c, vs pulse, page_i=1 -> line0=16'h1008, line7=16'h100F; page_i=2 -> all 0.
//  3 Freeze: freeze_i=1, change ch0 to 16'hBEEF, vs pulse -> line0 unchanged; freeze_i=0, vs pulse -> 16'hBEEF.
//  4 Trigger: arm, trig_ch=3, mask=16'h00FF, val=16'h0042; ch3=16'h7742 at cycle N -> state_o=10 at N+1,
//    lines_o=capture at N+2, hit_count_o=1; later probe changes and vs pulses do not alter lines_o.
//  5 Re-arm/saturation: arm in CAPTURED -> state_o=01 next cycle; force hit_count to 16'hFFFF, hit -> stays 16'hFFFF.
//  6 DBG_TICK_EN, TICK_DIV=4: tick_o pulses at cycles 4,8,12 after reset release; reset at cycle 6 -> next pulse 4 after release.

Source files
------------

// File: rtl/dbg_probe_capture.sv
// Probe front-end for the debug overlay: VSync-latched shadow, masked-compare trigger capture, paged line output.
// Optional slow tick generator is enabled by defining DBG_TICK_EN.
module dbg_probe_capture #(
  parameter int NCH      = 16,
  parameter int W        = 16,
  parameter int LINES    = 8,
  parameter int TICK_DIV = 5000000,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [NCH*W-1:0]     probe_i,
  input  logic                 vs_i,
  input  logic                 freeze_i,
  input  logic [7:0]           page_i,
  input  logic                 arm_i,
  input  logic [CHW-1:0]       trig_ch_i,
  input  logic [W-1:0]         trig_mask_i,
  input  logic [W-1:0]         trig_val_i,
  output logic [LINES*W-1:0]   lines_o,
  output logic [1:0]           state_o,
  output logic                 triggered_o,
  output logic [15:0]          hit_count_o,
  output logic                 tick_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ARMED    = 2'b01,
    ST_CAPTURED = 2'b10
  } state_t;

  state_t               state, state_nxt;
  logic                 vs_q;
  logic                 vs_rise;
  logic [W-1:0]         shadow  [NCH];
  logic [W-1:0]         capture [NCH];
  logic [15:0]          hit_count;
  logic [W-1:0]         trig_word;
  logic                 match;
  logic                 capture_en;
  logic [LINES*W-1:0]   lines_q, lines_nxt;

  assign vs_rise = vs_i & ~vs_q;

  // Channel selected for the trigger; indices beyond NCH can never match.
  always_comb begin
    trig_word = '0;
    for (int c = 0; c < NCH; c++) begin
      if (int'(trig_ch_i) == c) trig_word = probe_i[c*W +: W];
    end
    match = (int'(trig_ch_i) < NCH) && (((trig_word ^ trig_val_i) & trig_mask_i) == '0);
  end

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    capture_en = 1'b0;
    case (state)
      ST_IDLE:     if (arm_i) state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (match) begin
          capture_en = 1'b1;
          state_nxt  = ST_CAPTURED;
        end
      end
      ST_CAPTURED: if (arm_i) state_nxt = ST_ARMED;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_IDLE;
      vs_q      <= 1'b0;
      hit_count <= '0;
    end else begin
      state <= state_nxt;
      vs_q  <= vs_i;
      if (capture_en && (hit_count != 16'hFFFF)) hit_count <= hit_count + 16'd1;
    end
  end

  // NOTE: shadow and capture arrays are reset because the overlay may display them right after reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        shadow[c]  <= '0;
        capture[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (vs_rise && !freeze_i) shadow[c]  <= probe_i[c*W +: W];
        if (capture_en)           capture[c] <= probe_i[c*W +: W];
      end
    end
  end

  // Page index is formed in 32-bit arithmetic so high pages never alias onto low channels.
  always_comb begin
    lines_nxt = '0;
    for (int k = 0; k < LINES; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if (int'(page_i) * LINES + k == c)
          lines_nxt[k*W +: W] = (state == ST_CAPTURED) ? capture[c] : shadow[c];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) lines_q <= '0;
    else       lines_q <= lines_nxt;
  end

  assign lines_o     = lines_q;
  assign state_o     = state;
  assign triggered_o = (state == ST_CAPTURED);
  assign hit_count_o = hit_count;

`ifdef DBG_TICK_EN
  localparam int TCW = $clog2(TICK_DIV);

  logic [TCW-1:0] tick_cnt;
  logic           tick_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
    end else if (tick_cnt == TCW'(TICK_DIV - 1)) begin
      tick_cnt <= '0;
      tick_q   <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + TCW'(1);
      tick_q   <= 1'b0;
    end
  end

  assign tick_o = tick_q;
`else
  // Divider absent in this build; the parameter is still referenced to keep the interface uniform.
  logic tick_div_unused;
  assign tick_div_unused = (TICK_DIV < 2);
  assign tick_o          = 1'b0;
`endif

endmodule
